fetch_arbiter_scrubber: RTL and testbench
=========================================

Name: fetch_arbiter_scrubber

Overview:
- Controller that shares the 16-entry, two-bank fetch datapath between two requesters and a background parity scrubber.
- The fetch datapath takes a 4-bit address; bit 3 selects the bank. It returns an 8-bit word and a stored parity bit, both combinational.
- The block owns the datapath address, captures the word and parity, performs the even-XOR parity compare, and returns data plus an error flag to the owner of each access.
- During idle time it walks all 16 addresses, counts parity mismatches and logs the last failing address.

Parameters:
- SCRUB_EN, 1, 1 enables the background scrub; 0 means requester traffic only.
- IDLE_WAIT, 4, consecutive idle cycles (no request pending) required before a scrub access is issued; range 1..15.
- ERR_W, 4, width of the saturating error counter.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- reset  in  1  synchronous, active-low reset; reset==0 sampled at posedge clears all state.
- req0  in  1  requester 0 access request; held high until gnt0.
- addr0  in  4  requester 0 address; must be stable while req0 is high.
- req1  in  1  requester 1 access request; held high until gnt1.
- addr1  in  4  requester 1 address.
- gnt0  out  1  one-cycle pulse: addr0 accepted.
- gnt1  out  1  one-cycle pulse: addr1 accepted.
- rvalid0  out  1  one-cycle pulse: rdata/rerr are valid for requester 0.
- rvalid1  out  1  one-cycle pulse: rdata/rerr are valid for requester 1.
- rdata  out  8  captured word; shared by both requesters.
- rerr  out  1  1 = parity mismatch on the returned word.
- mem_addr  out  4  registered address driven to the fetch datapath.
- mem_data  in  8  word from the fetch datapath.
- mem_parity  in  1  stored parity bit from the fetch datapath.
- err_count  out  ERR_W  saturating count of mismatches from all sources.
- err_addr  out  4  address of the most recent mismatch.
- scrub_done  out  1  sticky; set when a full 0..15 scrub pass completes.

Behaviour:
- Reset (reset==0 at posedge):
  - state=IDLE; mem_addr=0; all gnt and rvalid outputs=0; rdata=0; rerr=0.
  - err_count=0; err_addr=0; scrub_done=0; scrub pointer=0; idle counter=0; round-robin pointer points at req0.
  - Reset asserted mid-access aborts the access: no rvalid is issued, and requesters must re-request.
- FSM has two states: IDLE and CAPTURE.
- IDLE:
  - Arbitrate among req0, req1 and the scrubber. The winner's address is registered into mem_addr, its gnt pulses in this same cycle, owner is recorded, and the FSM moves to CAPTURE.
  - req0 and req1 are round-robin. After a grant, priority moves to the other requester. With both high, they alternate 0,1,0,1.
  - The scrubber has lowest priority. It issues only when SCRUB_EN=1, no request is high, and the idle counter has reached IDLE_WAIT.
  - The idle counter increments each IDLE cycle with no request, saturates at IDLE_WAIT, and clears on any grant.
  - A scrub access produces no gnt or rvalid.
- CAPTURE (exactly one cycle):
  - rdata<=mem_data.
  - rerr<=((^mem_data)!=mem_parity).
  - The owner's rvalid pulses on the next cycle, together with valid rdata and rerr.
  - The FSM returns to IDLE.
  - No grant is issued in CAPTURE, so the maximum throughput is one access every 2 cycles.
  - Latency: gnt at cycle N, rvalid at cycle N+2.
- Error logging applies to any owner, requester or scrub:
  - On mismatch, err_addr<=mem_addr.
  - err_count increments and saturates at 2^ERR_W-1 with no wrap.
- Scrub pointer:
  - Increments after each scrub capture and wraps 15->0.
  - The wrap sets scrub_done, which stays set until reset.
  - Requester traffic does not move the pointer.
- A request that arrives while in CAPTURE waits; it is never dropped.
- rdata/rerr hold their value between accesses, including after scrub accesses. Requesters sample them only on their own rvalid.

Test Plan:
- Reset, then release: all outputs 0 for one cycle. With no requests and SCRUB_EN=1, first scrub mem_addr=0 issues after 4 idle cycles.
- req0 held with addr0=4'h0; datapath returns 8'h1F with parity 1 -> gnt0 at N, rvalid0 at N+2, rdata=8'h1F, rerr=0.
- req0 addr 4'h2 returns 8'h53 with parity 1 -> rerr=1, err_count=1, err_addr=4'h2.
- req0 and req1 both held continuously -> grants alternate gnt0, gnt1, gnt0, ... each 2 cycles apart. Scrubber issues nothing while requests are pending.
- No requests, full scrub pass with bank0 = 1F,31,53,75,97,B9,DB,FD (parity 1) and bank1 = 00,22,...,EE (parity 0) -> scrub_done=1, err_count=2, err_addr=4'h6.
- ERR_W=2 with repeated reads of addr 4'h2 -> err_count saturates at 3. Reset asserted during CAPTURE -> no rvalid, err_count=0.

Source files
------------

// File: rtl/fetch_arbiter_scrubber_if.sv
// Requester handshake and fetch-datapath bus shared by the arbiter/scrubber.
// The master side plays both requesters and the combinational fetch datapath.
interface fetch_arbiter_scrubber_if;
  logic       req0;
  logic [3:0] addr0;
  logic       req1;
  logic [3:0] addr1;
  logic       gnt0;
  logic       gnt1;
  logic       rvalid0;
  logic       rvalid1;
  logic [7:0] rdata;
  logic       rerr;
  logic [3:0] mem_addr;
  logic [7:0] mem_data;
  logic       mem_parity;

  modport master (
    output req0, addr0, req1, addr1, mem_data, mem_parity,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata, rerr, mem_addr
  );

  modport slave (
    input  req0, addr0, req1, addr1, mem_data, mem_parity,
    output gnt0, gnt1, rvalid0, rvalid1, rdata, rerr, mem_addr
  );
endinterface

// File: rtl/fetch_arbiter_scrubber.sv
// Shares a 16-entry fetch datapath between two round-robin requesters and a
// low-priority background parity scrubber; logs parity mismatches from all owners.
module fetch_arbiter_scrubber #(
  parameter bit SCRUB_EN  = 1'b1,
  parameter int IDLE_WAIT = 4,
  parameter int ERR_W     = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  fetch_arbiter_scrubber_if.slave bus,
  output logic [ERR_W-1:0]      err_count,
  output logic [3:0]            err_addr,
  output logic                  scrub_done
);

  typedef enum logic {IDLE, CAPTURE} state_t;
  typedef enum logic [1:0] {OWN_REQ0, OWN_REQ1, OWN_SCRUB} owner_t;

  localparam logic [3:0]       IDLE_WAIT_C = 4'(IDLE_WAIT);
  localparam logic [ERR_W-1:0] ERR_MAX     = '1;

  state_t     state, state_nxt;
  owner_t     owner, owner_nxt;
  logic [3:0] addr_nxt;
  logic [3:0] idle_cnt;
  logic [3:0] scrub_ptr;
  logic       rr_ptr;       // 0: req0 has priority, 1: req1 has priority
  logic       gnt0_c, gnt1_c, scrub_go, grant_any;
  logic       mismatch;

  assign mismatch = (^bus.mem_data) != bus.mem_parity;

  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    state_nxt = state;
    owner_nxt = owner;
    addr_nxt  = bus.mem_addr;
    gnt0_c    = 1'b0;
    gnt1_c    = 1'b0;
    scrub_go  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.req0 && (!bus.req1 || !rr_ptr)) begin
          gnt0_c    = 1'b1;
          owner_nxt = OWN_REQ0;
          addr_nxt  = bus.addr0;
        end else if (bus.req1) begin
          gnt1_c    = 1'b1;
          owner_nxt = OWN_REQ1;
          addr_nxt  = bus.addr1;
        end else if (SCRUB_EN && idle_cnt == IDLE_WAIT_C) begin
          scrub_go  = 1'b1;
          owner_nxt = OWN_SCRUB;
          addr_nxt  = scrub_ptr;
        end
        if (gnt0_c || gnt1_c || scrub_go) state_nxt = CAPTURE;
      end
      CAPTURE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign grant_any = gnt0_c | gnt1_c | scrub_go;

  // Grants are only meaningful when the register side will honour them.
  assign bus.gnt0 = gnt0_c & reset;
  assign bus.gnt1 = gnt1_c & reset;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (!reset) begin
      state        <= IDLE;
      owner        <= OWN_REQ0;
      bus.mem_addr <= '0;
      bus.rvalid0  <= 1'b0;
      bus.rvalid1  <= 1'b0;
      bus.rdata    <= '0;
      bus.rerr     <= 1'b0;
      err_count    <= '0;
      err_addr     <= '0;
      scrub_done   <= 1'b0;
      scrub_ptr    <= '0;
      idle_cnt     <= '0;
      rr_ptr       <= 1'b0;
    end else begin
      state        <= state_nxt;
      owner        <= owner_nxt;
      bus.mem_addr <= addr_nxt;
      bus.rvalid0  <= 1'b0;
      bus.rvalid1  <= 1'b0;

      if (state == IDLE) begin
        if (grant_any)                  idle_cnt <= '0;
        else if (idle_cnt != IDLE_WAIT_C) idle_cnt <= idle_cnt + 4'd1;
        if (gnt0_c)      rr_ptr <= 1'b1;
        else if (gnt1_c) rr_ptr <= 1'b0;
      end

      if (state == CAPTURE) begin
        // Scrub reads leave the requester-visible rdata/rerr untouched.
        if (owner == OWN_SCRUB) begin
          scrub_ptr <= scrub_ptr + 4'd1;
          if (scrub_ptr == 4'hF) scrub_done <= 1'b1;
        end else begin
          bus.rdata   <= bus.mem_data;
          bus.rerr    <= mismatch;
          bus.rvalid0 <= (owner == OWN_REQ0);
          bus.rvalid1 <= (owner == OWN_REQ1);
        end
        if (mismatch) begin
          err_addr <= bus.mem_addr;
          if (err_count != ERR_MAX) err_count <= err_count + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_arbiter_scrubber.sv
// Directed bench: instance A exercises scrub timing and arbitration,
// instance B (no scrub, 2-bit counter) exercises data, errors and abort.
module tb_fetch_arbiter_scrubber;

  logic clk = 1'b0;
  logic rst_a, rst_b;
  always #5 clk = ~clk;

  fetch_arbiter_scrubber_if bus_a ();
  fetch_arbiter_scrubber_if bus_b ();

  logic [3:0] err_count_a;
  logic [3:0] err_addr_a;
  logic       scrub_done_a;
  logic [1:0] err_count_b;
  logic [3:0] err_addr_b;
  logic       scrub_done_b;

  fetch_arbiter_scrubber #(.SCRUB_EN(1'b1), .IDLE_WAIT(4), .ERR_W(4)) dut_a (
    .clk(clk), .reset(rst_a), .bus(bus_a),
    .err_count(err_count_a), .err_addr(err_addr_a), .scrub_done(scrub_done_a)
  );

  fetch_arbiter_scrubber #(.SCRUB_EN(1'b0), .IDLE_WAIT(4), .ERR_W(2)) dut_b (
    .clk(clk), .reset(rst_b), .bus(bus_b),
    .err_count(err_count_b), .err_addr(err_addr_b), .scrub_done(scrub_done_b)
  );

  // Fetch datapath model: bank0 odd-parity-ish words with parity 1, bank1 parity 0.
  logic [7:0] mem [16];
  logic       par [16];
  initial begin
    mem[0]  = 8'h1F; mem[1]  = 8'h31; mem[2]  = 8'h53; mem[3]  = 8'h75;
    mem[4]  = 8'h97; mem[5]  = 8'hB9; mem[6]  = 8'hDB; mem[7]  = 8'hFD;
    for (int i = 0; i < 8; i++) begin
      mem[8+i] = 8'(i * 8'h22);
      par[i]   = 1'b1;
      par[8+i] = 1'b0;
    end
  end
  assign bus_a.mem_data   = mem[bus_a.mem_addr];
  assign bus_a.mem_parity = par[bus_a.mem_addr];
  assign bus_b.mem_data   = mem[bus_b.mem_addr];
  assign bus_b.mem_parity = par[bus_b.mem_addr];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // One requester access on instance B: gnt at N, rvalid at N+2.
  task automatic access_b(input bit which, input logic [3:0] a,
                          input logic [7:0] exp_d, input bit exp_e);
    bit got = 1'b0;
    if (!which) begin bus_b.req0 = 1'b1; bus_b.addr0 = a; end
    else        begin bus_b.req1 = 1'b1; bus_b.addr1 = a; end
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      got = which ? bus_b.gnt1 : bus_b.gnt0;
      @(posedge clk); #1;
    end
    check("b_gnt", 32'(got), 32'd1);
    bus_b.req0 = 1'b0;
    bus_b.req1 = 1'b0;
    @(negedge clk);
    check("b_rvalid_n1", 32'(which ? bus_b.rvalid1 : bus_b.rvalid0), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("b_rvalid_n2", 32'(which ? bus_b.rvalid1 : bus_b.rvalid0), 32'd1);
    check("b_rdata", 32'(bus_b.rdata), 32'(exp_d));
    check("b_rerr", 32'(bus_b.rerr), 32'(exp_e));
    @(posedge clk); #1;
  endtask

  initial begin
    int first_done;
    bit got, g0, g1;
    bus_a.req0 = 1'b0; bus_a.req1 = 1'b0; bus_a.addr0 = '0; bus_a.addr1 = '0;
    bus_b.req0 = 1'b0; bus_b.req1 = 1'b0; bus_b.addr0 = '0; bus_b.addr1 = '0;
    rst_a = 1'b0;
    rst_b = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // ---- Instance A: reset values and first-scrub timing ----
    rst_a = 1'b1;
    @(negedge clk);
    check("a_rst_mem_addr", 32'(bus_a.mem_addr), 32'd0);
    check("a_rst_gnt", 32'({bus_a.gnt0, bus_a.gnt1}), 32'd0);
    check("a_rst_rvalid", 32'({bus_a.rvalid0, bus_a.rvalid1}), 32'd0);
    check("a_rst_rdata", 32'(bus_a.rdata), 32'd0);
    check("a_rst_err", 32'({err_count_a, err_addr_a, scrub_done_a, bus_a.rerr}), 32'd0);
    repeat (5) @(posedge clk);
    #1;
    // Cycle 5: the scrub issued after 4 idle cycles occupies the datapath.
    bus_a.req0 = 1'b1; bus_a.addr0 = 4'h1;
    @(negedge clk);
    check("a_scrub_blocks_gnt", 32'(bus_a.gnt0), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("a_gnt_after_scrub", 32'(bus_a.gnt0), 32'd1);
    @(posedge clk); #1;
    bus_a.req0 = 1'b0;
    @(negedge clk);
    check("a_mem_addr_req", 32'(bus_a.mem_addr), 32'h1);
    @(posedge clk); #1;

    // ---- Instance A: full scrub pass from reset ----
    rst_a = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_a = 1'b1;
    first_done = -1;
    for (int k = 0; k <= 100; k++) begin
      @(negedge clk);
      if (scrub_done_a && first_done < 0) first_done = k;
      @(posedge clk); #1;
    end
    check("a_scrub_done_cycle", 32'(first_done), 32'd96);
    check("a_scrub_err_count", 32'(err_count_a), 32'd2);
    check("a_scrub_err_addr", 32'(err_addr_a), 32'h6);

    // ---- Instance A: both requesters held, strict alternation ----
    bus_a.req0 = 1'b1; bus_a.addr0 = 4'h1;
    bus_a.req1 = 1'b1; bus_a.addr1 = 4'h9;
    got = 1'b0; g0 = 1'b0; g1 = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      g0 = bus_a.gnt0; g1 = bus_a.gnt1;
      got = g0 | g1;
      @(posedge clk); #1;
    end
    check("a_alt_first_gnt0", 32'({g0, g1}), 32'b10);
    for (int j = 1; j < 12; j++) begin
      @(negedge clk);
      check("a_alt_gnt0", 32'(bus_a.gnt0), 32'((j % 2 == 0) && ((j / 2) % 2 == 0)));
      check("a_alt_gnt1", 32'(bus_a.gnt1), 32'((j % 2 == 0) && ((j / 2) % 2 == 1)));
      if (j % 2 == 1)
        check("a_alt_mem_addr", 32'(bus_a.mem_addr), ((j / 2) % 2 == 0) ? 32'h1 : 32'h9);
      @(posedge clk); #1;
    end
    bus_a.req0 = 1'b0;
    bus_a.req1 = 1'b0;

    // ---- Instance B: reset, data return, errors, saturation ----
    rst_b = 1'b1;
    @(negedge clk);
    check("b_rst_outputs", 32'({bus_b.gnt0, bus_b.gnt1, bus_b.rvalid0, bus_b.rvalid1,
                                bus_b.rerr, scrub_done_b}), 32'd0);
    check("b_rst_regs", 32'({bus_b.rdata, bus_b.mem_addr, err_count_b, err_addr_b}), 32'd0);
    @(posedge clk); #1;

    access_b(1'b0, 4'h0, 8'h1F, 1'b0);
    check("b_err_count_0", 32'(err_count_b), 32'd0);
    access_b(1'b0, 4'h2, 8'h53, 1'b1);
    check("b_err_count_1", 32'(err_count_b), 32'd1);
    check("b_err_addr_2", 32'(err_addr_b), 32'h2);
    access_b(1'b1, 4'h9, 8'h22, 1'b0);
    check("b_err_count_hold", 32'(err_count_b), 32'd1);
    for (int k = 2; k <= 4; k++) begin
      access_b(1'b0, 4'h2, 8'h53, 1'b1);
      check("b_err_count_sat", 32'(err_count_b), (k > 3) ? 32'd3 : 32'(k));
    end

    // ---- Instance B: reset during CAPTURE aborts the access ----
    bus_b.req0 = 1'b1; bus_b.addr0 = 4'h2;
    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      got = bus_b.gnt0;
      @(posedge clk); #1;
    end
    check("b_abort_gnt", 32'(got), 32'd1);
    bus_b.req0 = 1'b0;
    rst_b = 1'b0;
    @(posedge clk); #1;
    rst_b = 1'b1;
    @(negedge clk);
    check("b_abort_rvalid", 32'(bus_b.rvalid0), 32'd0);
    check("b_abort_err_count", 32'(err_count_b), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("b_abort_rvalid_late", 32'(bus_b.rvalid0), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
